// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// With DIV_ZERO_FLAG_EN defined, the bundle also carries the divide-by-zero flag div_zero_o.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
    input  div_zero_o,
`endif
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
`ifdef DIV_ZERO_FLAG_EN
    output div_zero_o,
`endif
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU), one quotient bit per clock, result {rem, quo}.
// Optional macro DIV_ZERO_FLAG_EN adds div_zero_o, raised with ready_o for a zero divisor.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

  state_e              state_q, state_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
  logic                dz_q, dz_d;
`endif

  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   abs_dvd, abs_dvs, quo, rem;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d      = dz_q;
`endif
    // Trial subtraction of the divisor from the upper half of the partial remainder.
    diff    = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    abs_dvd = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    abs_dvs = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    quo     = neg_quo_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem     = neg_rem_q ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];

    unique case (state_q)
      S_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d   = S_ON;
            divisor_d = abs_dvs;
            work_d    = {DATA_W'(0), abs_dvd, 1'b0};
            cnt_d     = '0;
            neg_quo_d = bus.signed_div_i && (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_rem_d = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
          end
        end
      end
      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
        dz_d     = 1'b1;
`endif
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          work_d = diff[DATA_W] ? {work_q[2*DATA_W-1:0], 1'b0}
                                : {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          state_d  = S_END;
          result_d = {rem, quo};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          dz_d     = 1'b0;
`endif
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      work_q    <= '0;
      cnt_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.div_zero_o = dz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides, latency, stall, annul and reset cases.
module tb_div_unit;

  typedef struct {
    logic [63:0] res;
    int          lat;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   start_cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic ready_prev = 1'b0;
  exp_t sb[$];

  div_if bus ();

  div_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: on each rising ready_o, pop the expected response and compare.
  always @(negedge clk) begin
    if (!rst && bus.ready_o && !ready_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result 0x%0h, expected no response", bus.result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result_o, e.res);
        chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero", 64'(bus.div_zero_o), 64'(e.dz));
`endif
      end
    end
    ready_prev <= bus.ready_o;
  end

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] res, input int lat);
    exp_t e;
    int   stall_cnt;
    int   waited;
    e.res = res;
    e.lat = lat;
    e.dz  = (b == 32'd0);
    sb.push_back(e);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    start_cyc        = cyc;
    stall_cnt        = 0;
    waited           = 0;
    forever begin
      #1;
      if (bus.stallreq_o) stall_cnt++;
      if (bus.ready_o) break;
      @(negedge clk);
      waited++;
      // Operands are garbage once accepted; the divider must ignore them.
      if (waited == 1) begin
        bus.opdata1_i = a ^ 32'h5A5A_1234;
        bus.opdata2_i = 32'd0;
      end
      if (waited > 100) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got no ready after %0d cycles, expected %0d", waited, lat);
        break;
      end
    end
    chk("stall_cycles", 64'(stall_cnt), 64'(lat));
    // Annul in END must be ignored while start is held.
    @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    chk("hold_stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    chk("hold_ready", 64'(bus.ready_o), 64'd1);
    chk("hold_result", bus.result_o, res);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(bus.ready_o), 64'd0);
    chk("drop_result", bus.result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("drop_div_zero", 64'(bus.div_zero_o), 64'd0);
`endif
  endtask

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        34);
    @(negedge clk);
    do_div(1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    @(negedge clk);
    do_div(1'b0, 32'hFFFF_FFF9,  32'd2,        {32'd1,        32'h7FFF_FFFC}, 34);
    @(negedge clk);
    do_div(1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,        32'hFFFF_FFFD}, 34);
    @(negedge clk);
    do_div(1'b0, 32'hFFFF_FFFF,  32'd1,        {32'd0,        32'hFFFF_FFFF}, 34);
    @(negedge clk);
    do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'd0,        32'h8000_0000}, 34);
    @(negedge clk);
    do_div(1'b0, 32'd1234,       32'd0,        64'd0,                          2);
    @(negedge clk);

    // Annul on the 10th ON cycle: back to FREE with no response.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    chk("annul_result", bus.result_o, 64'd0);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);
    @(negedge clk);

    // Synchronous reset on the 20th ON cycle aborts the divide.
    bus.opdata1_i = 32'd77;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (20) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34);
    repeat (40) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
